// File: rtl/d_kes_pkg.sv
// Shared definitions for the KES discrepancy-computation slice.
// Holds the default field parameters, the GF element type and the
// one-hot state encoding used by the accumulating DC PE.
package d_kes_pkg;

  localparam int          GF_ORDER_DEF = 12;
  localparam logic [12:0] GF_POLY_DEF  = 13'h1053;  // x^12 + x^6 + x^4 + x + 1

  typedef bit [GF_ORDER_DEF-1:0] gf_elem_t;

  // One-hot state encoding of the DC PE controller.
  typedef enum logic [3:0] {
    ST_IDLE = 4'b0001,
    ST_CAP  = 4'b0010,
    ST_ACC  = 4'b0100,
    ST_DONE = 4'b1000
  } state_t;

endpackage

// File: rtl/d_kes_gf_mul.sv
// Combinational parallel GF(2^GF_ORDER) multiplier.
// Ports:
//   i_a, i_b : GF_ORDER-bit field elements
//   o_p      : i_a * i_b reduced modulo GF_POLY
module d_kes_gf_mul
  import d_kes_pkg::*;
#(
  parameter int                GF_ORDER = GF_ORDER_DEF,
  parameter logic [GF_ORDER:0] GF_POLY  = (GF_ORDER+1)'(GF_POLY_DEF)
) (
  input  logic [GF_ORDER-1:0] i_a,
  input  logic [GF_ORDER-1:0] i_b,
  output logic [GF_ORDER-1:0] o_p
);

  // Carry-less multiply, then fold the high terms back from the top down so
  // each fold can only disturb bits that have not been examined yet.
  function automatic logic [GF_ORDER-1:0] gf_mul(input logic [GF_ORDER-1:0] a,
                                                 input logic [GF_ORDER-1:0] b);
    logic [2*GF_ORDER-2:0] prod;
    logic [2*GF_ORDER-2:0] a_ext;
    logic [2*GF_ORDER-2:0] poly_ext;
    prod     = '0;
    a_ext    = {{(GF_ORDER-1){1'b0}}, a};
    poly_ext = {{(GF_ORDER-2){1'b0}}, GF_POLY};
    for (int i = 0; i < GF_ORDER; i++) begin
      prod = prod ^ ((a_ext << i) & {(2*GF_ORDER-1){b[i]}});
    end
    for (int i = 2*GF_ORDER-2; i >= GF_ORDER; i--) begin
      prod = prod ^ ((poly_ext << (i - GF_ORDER)) & {(2*GF_ORDER-1){prod[i]}});
    end
    return prod[GF_ORDER-1:0];
  endfunction

  assign o_p = gf_mul(i_a, i_b);

endmodule

// File: rtl/d_kes_pe_dc_acc.sv
// Multi-lane, multi-beat discrepancy-computation PE for the BCH KES stage.
// Accumulates d = XOR_j S_j * v_j over LANES terms per beat and up to
// MAX_BEATS beats, and forwards the last captured syndromes to the next PE.
// Ports:
//   i_clk, i_RESET_KES_n : clock, async active-low reset
//   i_stop_dec           : synchronous abort (priority over i_start)
//   i_start, i_num_beats : start pulse (IDLE only) and beat count
//   i_valid, i_lane_mask : beat strobe (no backpressure), per-lane enable
//   i_S_in, i_v_2i_X     : packed syndromes / locator coefficients
//   o_S_out              : registered copy of the last captured i_S_in
//   o_busy, o_dc_valid   : busy flag, one-cycle result strobe
//   o_dc                 : discrepancy, held until the next accepted start
module d_kes_pe_dc_acc
  import d_kes_pkg::*;
#(
  parameter int                GF_ORDER  = GF_ORDER_DEF,
  parameter logic [GF_ORDER:0] GF_POLY   = (GF_ORDER+1)'(GF_POLY_DEF),
  parameter int                LANES     = 4,
  parameter int                MAX_BEATS = 8,
  parameter int                BW        = 4
) (
  input  logic                      i_clk,
  input  logic                      i_RESET_KES_n,
  input  logic                      i_stop_dec,
  input  logic                      i_start,
  input  logic [BW-1:0]             i_num_beats,
  input  logic                      i_valid,
  input  logic [LANES-1:0]          i_lane_mask,
  input  logic [LANES*GF_ORDER-1:0] i_S_in,
  input  logic [LANES*GF_ORDER-1:0] i_v_2i_X,
  output logic [LANES*GF_ORDER-1:0] o_S_out,
  output logic                      o_busy,
  output logic                      o_dc_valid,
  output logic [GF_ORDER-1:0]       o_dc
);

  localparam logic [BW-1:0] MAX_BEATS_W = BW'(MAX_BEATS);

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [BW-1:0]             r_cnt;
  logic                      r_pending;
  logic [LANES*GF_ORDER-1:0] r_s_cap;
  logic [LANES*GF_ORDER-1:0] r_v_cap;
  logic [LANES-1:0]          r_mask_cap;
  logic [GF_ORDER-1:0]       r_acc;
  logic [GF_ORDER-1:0]       r_dc;
  logic                      r_busy;
  logic                      r_dc_valid;
  logic [BW-1:0]             w_beats_sat;
  logic [GF_ORDER-1:0]       w_lane_prod [LANES];
  logic [GF_ORDER-1:0]       w_term;

  assign w_beats_sat = (i_num_beats > MAX_BEATS_W) ? MAX_BEATS_W : i_num_beats;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    d_kes_gf_mul #(.GF_ORDER(GF_ORDER), .GF_POLY(GF_POLY)) u_mul (
      .i_a (r_s_cap[k*GF_ORDER +: GF_ORDER]),
      .i_b (r_v_cap[k*GF_ORDER +: GF_ORDER]),
      .o_p (w_lane_prod[k])
    );
  end

  // XOR-reduce the products of the enabled lanes of the captured beat.
  always_comb begin
    w_term = '0;
    for (int k = 0; k < LANES; k++) begin
      w_term = w_term ^ (w_lane_prod[k] & {GF_ORDER{r_mask_cap[k]}});
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_RESET_KES_n) begin
    if (!i_RESET_KES_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; abort overrides everything.
  always_comb begin
    w_state_nxt = r_state;
    if (i_stop_dec) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            w_state_nxt = (w_beats_sat == {BW{1'b0}}) ? ST_DONE : ST_CAP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_CAP: begin
          // Counter hits zero on this edge: the beat just taken is the last.
          if (i_valid && (r_cnt == BW'(1))) begin
            w_state_nxt = ST_ACC;
          end else begin
            w_state_nxt = ST_CAP;
          end
        end
        ST_ACC:  w_state_nxt = ST_DONE;
        ST_DONE: w_state_nxt = ST_IDLE;
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Capture, accumulate and result registers.
  always_ff @(posedge i_clk or negedge i_RESET_KES_n) begin
    if (!i_RESET_KES_n) begin
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_s_cap    <= '0;
      r_v_cap    <= '0;
      r_mask_cap <= '0;
      r_acc      <= '0;
      r_dc       <= '0;
      r_busy     <= 1'b0;
      r_dc_valid <= 1'b0;
    end else if (i_stop_dec) begin
      r_cnt      <= '0;
      r_pending  <= 1'b0;
      r_s_cap    <= '0;
      r_v_cap    <= '0;
      r_mask_cap <= '0;
      r_acc      <= '0;
      r_dc       <= '0;
      r_busy     <= 1'b0;
      r_dc_valid <= 1'b0;
    end else begin
      r_dc_valid <= 1'b0;
      r_pending  <= 1'b0;
      // A beat captured on the previous edge is folded in now, in any state,
      // so back-to-back captures and accumulates overlap.
      if (r_pending) begin
        r_acc <= r_acc ^ w_term;
      end
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc  <= '0;
            r_dc   <= '0;
            r_cnt  <= w_beats_sat;
            r_busy <= 1'b1;
          end
        end
        ST_CAP: begin
          if (i_valid) begin
            r_s_cap    <= i_S_in;
            r_v_cap    <= i_v_2i_X;
            r_mask_cap <= i_lane_mask;
            r_pending  <= 1'b1;
            r_cnt      <= r_cnt - BW'(1);
          end
        end
        ST_ACC: begin
          r_cnt <= r_cnt;
        end
        ST_DONE: begin
          r_dc       <= r_acc;
          r_dc_valid <= 1'b1;
          r_busy     <= 1'b0;
        end
        default: begin
          r_busy <= 1'b0;
        end
      endcase
    end
  end

  assign o_S_out    = r_s_cap;
  assign o_busy     = r_busy;
  assign o_dc_valid = r_dc_valid;
  assign o_dc       = r_dc;

endmodule

// File: tb/tb_d_kes_pe_dc_acc.sv
// Directed self-checking bench for d_kes_pe_dc_acc (LANES=4, GF(2^12)).
module tb_d_kes_pe_dc_acc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stop_dec;
  logic        start;
  logic [3:0]  num_beats;
  logic        valid;
  logic [3:0]  lane_mask;
  logic [47:0] s_in;
  logic [47:0] v_in;
  logic [47:0] s_out;
  logic        busy;
  logic        dc_valid;
  logic [11:0] dc;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  d_kes_pe_dc_acc dut (
    .i_clk         (clk),
    .i_RESET_KES_n (rst_n),
    .i_stop_dec    (stop_dec),
    .i_start       (start),
    .i_num_beats   (num_beats),
    .i_valid       (valid),
    .i_lane_mask   (lane_mask),
    .i_S_in        (s_in),
    .i_v_2i_X      (v_in),
    .o_S_out       (s_out),
    .o_busy        (busy),
    .o_dc_valid    (dc_valid),
    .o_dc          (dc)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [3:0] nb);
    start = 1'b1; num_beats = nb;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [47:0] s, input logic [47:0] v, input logic [3:0] m);
    valid = 1'b1; s_in = s; v_in = v; lane_mask = m;
    tick();
    valid = 1'b0;
  endtask

  // Returns the number of edges until o_dc_valid is seen, -1 on timeout.
  task automatic wait_valid(output int n);
    n = -1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (dc_valid) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stop_dec = 1'b0; start = 1'b0; num_beats = 4'd0;
    valid = 1'b0; lane_mask = 4'd0; s_in = 48'd0; v_in = 48'd0;
    #12;
    if (dc !== 12'h000) $display("FAIL rst_dc: got %h want %h", dc, 12'h000); else n_pass++;
    n_checks++;
    if (dc_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", dc_valid); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++;
    if (s_out !== 48'd0) $display("FAIL rst_sout: got %h want 0", s_out); else n_pass++;
    n_checks++;
    rst_n = 1'b1;
  endtask

  task automatic test_identity();
    int n;
    start_op(4'd1);
    if (busy !== 1'b1) $display("FAIL id_busy_start: got %b want 1", busy); else n_pass++;
    n_checks++;
    beat({12'hFFF, 12'hABC, 12'h777, 12'h123}, {12'h555, 12'h0F0, 12'h3C3, 12'h001}, 4'b0001);
    if (s_out !== {12'hFFF, 12'hABC, 12'h777, 12'h123})
      $display("FAIL id_sout: got %h want %h", s_out, {12'hFFF, 12'hABC, 12'h777, 12'h123});
    else n_pass++;
    n_checks++;
    wait_valid(n);
    if (n !== 2) $display("FAIL id_latency: got %0d want 2", n); else n_pass++;
    n_checks++;
    if (dc !== 12'h123) $display("FAIL id_dc: got %h want %h", dc, 12'h123); else n_pass++;
    n_checks++;
    if (busy !== 1'b0) $display("FAIL id_busy_end: got %b want 0", busy); else n_pass++;
    n_checks++;
    tick();
    if (dc_valid !== 1'b0) $display("FAIL id_pulse_width: got %b want 0", dc_valid); else n_pass++;
    n_checks++;
    if (dc !== 12'h123) $display("FAIL id_dc_hold: got %h want %h", dc, 12'h123); else n_pass++;
    n_checks++;
  endtask

  task automatic test_reduction();
    int n;
    start_op(4'd1);
    beat({12'h0, 12'h0, 12'h0, 12'h800}, {12'h0, 12'h0, 12'h0, 12'h002}, 4'b0001);
    wait_valid(n);
    if (n !== 2 || dc !== 12'h053) $display("FAIL red_one_lane: got %h (n=%0d) want %h", dc, n, 12'h053); else n_pass++;
    n_checks++;
    start_op(4'd1);
    beat({12'h0, 12'h0, 12'h002, 12'h800}, {12'h0, 12'h0, 12'h002, 12'h002}, 4'b0011);
    wait_valid(n);
    if (n !== 2 || dc !== 12'h057) $display("FAIL red_two_lane: got %h (n=%0d) want %h", dc, n, 12'h057); else n_pass++;
    n_checks++;
  endtask

  task automatic test_back_to_back();
    int n;
    int c0;
    start_op(4'd3);
    c0 = cyc;
    beat({12'h111, 12'h222, 12'h333, 12'h001}, {12'h444, 12'h555, 12'h666, 12'h00F}, 4'b0001);
    beat({12'h111, 12'h222, 12'h333, 12'h001}, {12'h444, 12'h555, 12'h666, 12'h0F0}, 4'b0001);
    beat({12'h111, 12'h222, 12'h333, 12'h001}, {12'h444, 12'h555, 12'h666, 12'hF00}, 4'b0001);
    wait_valid(n);
    if (dc !== 12'hFFF) $display("FAIL b2b_dc: got %h want %h", dc, 12'hFFF); else n_pass++;
    n_checks++;
    if (n !== 2 || (cyc - c0) !== 5) $display("FAIL b2b_latency: got %0d want 5", cyc - c0); else n_pass++;
    n_checks++;
    start_op(4'd3);
    c0 = cyc;
    beat({12'h0, 12'h0, 12'h0, 12'h001}, {12'h0, 12'h0, 12'h0, 12'h00F}, 4'b0001);
    tick();
    if (busy !== 1'b1 || dc_valid !== 1'b0) $display("FAIL gap_wait: got busy=%b valid=%b want 1/0", busy, dc_valid); else n_pass++;
    n_checks++;
    beat({12'h0, 12'h0, 12'h0, 12'h001}, {12'h0, 12'h0, 12'h0, 12'h0F0}, 4'b0001);
    beat({12'h0, 12'h0, 12'h0, 12'h001}, {12'h0, 12'h0, 12'h0, 12'hF00}, 4'b0001);
    wait_valid(n);
    if (dc !== 12'hFFF) $display("FAIL gap_dc: got %h want %h", dc, 12'hFFF); else n_pass++;
    n_checks++;
    if (n !== 2 || (cyc - c0) !== 6) $display("FAIL gap_latency: got %0d want 6", cyc - c0); else n_pass++;
    n_checks++;
  endtask

  task automatic test_saturation();
    int n;
    logic [11:0] v0;
    start_op(4'd15);
    for (int b = 1; b <= 8; b++) begin
      v0 = 12'(b);
      if (b == 8) begin
        if (busy !== 1'b1 || dc_valid !== 1'b0) $display("FAIL sat_busy: got busy=%b valid=%b want 1/0", busy, dc_valid); else n_pass++;
        n_checks++;
      end
      beat({12'hAAA, 12'hBBB, 12'hCCC, 12'h001}, {12'h0, 12'h0, 12'h0, v0}, 4'b0001);
    end
    wait_valid(n);
    if (n !== 2 || dc !== 12'h008) $display("FAIL sat_dc: got %h (n=%0d) want %h", dc, n, 12'h008); else n_pass++;
    n_checks++;
  endtask

  task automatic test_zero_beats();
    int n;
    start_op(4'd1);
    beat({12'h0, 12'h0, 12'h0, 12'h123}, {12'h0, 12'h0, 12'h0, 12'h001}, 4'b0001);
    wait_valid(n);
    start = 1'b1; num_beats = 4'd0;
    valid = 1'b1; s_in = {12'h999, 12'h888, 12'h777, 12'h666}; lane_mask = 4'hF;
    tick();
    start = 1'b0;
    if (busy !== 1'b1 || dc !== 12'h000) $display("FAIL zero_start: got busy=%b dc=%h want 1/000", busy, dc); else n_pass++;
    n_checks++;
    tick();
    valid = 1'b0;
    if (dc_valid !== 1'b1 || dc !== 12'h000) $display("FAIL zero_result: got valid=%b dc=%h want 1/000", dc_valid, dc); else n_pass++;
    n_checks++;
    if (s_out !== {12'h0, 12'h0, 12'h0, 12'h123}) $display("FAIL zero_sout: got %h want %h", s_out, {12'h0, 12'h0, 12'h0, 12'h123}); else n_pass++;
    n_checks++;
  endtask

  task automatic test_abort();
    int n;
    int seen;
    start_op(4'd4);
    beat({12'h0, 12'h0, 12'h0, 12'h001}, {12'h0, 12'h0, 12'h0, 12'h111}, 4'b0001);
    beat({12'h0, 12'h0, 12'h0, 12'h001}, {12'h0, 12'h0, 12'h0, 12'h222}, 4'b0001);
    stop_dec = 1'b1;
    tick();
    if (busy !== 1'b0 || dc !== 12'h000 || s_out !== 48'd0)
      $display("FAIL abort_clear: got busy=%b dc=%h sout=%h want 0/000/0", busy, dc, s_out);
    else n_pass++;
    n_checks++;
    start = 1'b1; num_beats = 4'd1;
    tick();
    start = 1'b0; stop_dec = 1'b0;
    if (busy !== 1'b0) $display("FAIL abort_priority: got busy=%b want 0", busy); else n_pass++;
    n_checks++;
    seen = 0;
    valid = 1'b1; s_in = {12'h5A5, 12'h5A5, 12'h5A5, 12'h5A5}; lane_mask = 4'hF;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (dc_valid) seen++;
    end
    valid = 1'b0;
    if (seen !== 0 || s_out !== 48'd0) $display("FAIL abort_idle: got pulses=%0d sout=%h want 0/0", seen, s_out); else n_pass++;
    n_checks++;
    start_op(4'd1);
    beat({12'h0, 12'h0, 12'h0, 12'h003}, {12'h0, 12'h0, 12'h0, 12'h003}, 4'b0001);
    wait_valid(n);
    if (n !== 2 || dc !== 12'h005) $display("FAIL abort_restart: got %h (n=%0d) want %h", dc, n, 12'h005); else n_pass++;
    n_checks++;
  endtask

  task automatic test_busy_ignore();
    int n;
    start_op(4'd2);
    start = 1'b1; num_beats = 4'd0;
    beat({12'h0, 12'h0, 12'h0, 12'h002}, {12'h0, 12'h0, 12'h0, 12'h003}, 4'b0001);
    start = 1'b0;
    beat({12'h0, 12'h0, 12'h0, 12'h004}, {12'h0, 12'h0, 12'h0, 12'h004}, 4'b0001);
    valid = 1'b1; s_in = {12'hEEE, 12'hEEE, 12'hEEE, 12'hEEE}; v_in = {4{12'h001}}; lane_mask = 4'hF;
    tick();
    valid = 1'b0;
    if (s_out !== {12'h0, 12'h0, 12'h0, 12'h004}) $display("FAIL busy_sout: got %h want %h", s_out, {12'h0, 12'h0, 12'h0, 12'h004}); else n_pass++;
    n_checks++;
    wait_valid(n);
    if (n !== 1 || dc !== 12'h016) $display("FAIL busy_dc: got %h (n=%0d) want %h", dc, n, 12'h016); else n_pass++;
    n_checks++;
  endtask

  task automatic test_async_reset();
    int n;
    int seen;
    start_op(4'd1);
    beat({12'h0, 12'h0, 12'h0, 12'h123}, {12'h0, 12'h0, 12'h0, 12'h001}, 4'b0001);
    #2;
    rst_n = 1'b0;
    #1;
    if (busy !== 1'b0 || dc_valid !== 1'b0 || dc !== 12'h000 || s_out !== 48'd0)
      $display("FAIL async_rst: got busy=%b valid=%b dc=%h sout=%h want all 0", busy, dc_valid, dc, s_out);
    else n_pass++;
    n_checks++;
    #2;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (dc_valid) seen++;
    end
    if (seen !== 0) $display("FAIL async_no_valid: got %0d pulses want 0", seen); else n_pass++;
    n_checks++;
    start_op(4'd2);
    beat({12'h0, 12'h0, 12'h0, 12'h002}, {12'h0, 12'h0, 12'h0, 12'h002}, 4'b0001);
    beat({12'h0, 12'h0, 12'h0, 12'h800}, {12'h0, 12'h0, 12'h0, 12'h002}, 4'b0001);
    wait_valid(n);
    if (n !== 2 || dc !== 12'h057) $display("FAIL async_restart: got %h (n=%0d) want %h", dc, n, 12'h057); else n_pass++;
    n_checks++;
  endtask

  initial begin
    test_reset();
    test_identity();
    test_reduction();
    test_back_to_back();
    test_saturation();
    test_zero_beats();
    test_abort();
    test_busy_ignore();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
